// File: rtl/rect_fill.sv
// ============================================================================
// rect_fill : raster-order rectangle fill engine with screen clipping
// Rev 1.0
// ============================================================================
`default_nettype none

module rect_fill #(
  parameter int X_MAX = 160,
  parameter int Y_MAX = 120
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       start,
  input  logic [7:0] x0,
  input  logic [6:0] y0,
  input  logic [7:0] width,
  input  logic [6:0] height,
  input  logic [2:0] color,
  output logic [7:0] VGA_X,
  output logic [6:0] VGA_Y,
  output logic [2:0] VGA_COLOR,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  localparam logic [8:0] c_x_lim = X_MAX[8:0];
  localparam logic [7:0] c_y_lim = Y_MAX[7:0];

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;

  logic [7:0] r_x0;
  logic [6:0] r_y0;
  logic [7:0] r_w;
  logic [6:0] r_h;
  logic [2:0] r_color;
  logic [7:0] r_i;
  logic [6:0] r_j;

  logic       w_load;
  logic [7:0] w_i_nxt;
  logic [6:0] w_j_nxt;
  logic       w_emit;
  logic [7:0] w_base_x;
  logic [6:0] w_base_y;
  logic [2:0] w_color;
  logic [8:0] w_px_x;
  logic [7:0] w_px_y;
  logic       w_visible;
  logic       w_last;
  logic       w_plot_nxt;
  logic [7:0] w_vga_x_nxt;
  logic [6:0] w_vga_y_nxt;
  logic [2:0] w_vga_color_nxt;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_state   <= IDLE;
      r_x0      <= '0;
      r_y0      <= '0;
      r_w       <= '0;
      r_h       <= '0;
      r_color   <= '0;
      r_i       <= '0;
      r_j       <= '0;
      VGA_X     <= '0;
      VGA_Y     <= '0;
      VGA_COLOR <= '0;
      plot      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_i       <= w_i_nxt;
      r_j       <= w_j_nxt;
      VGA_X     <= w_vga_x_nxt;
      VGA_Y     <= w_vga_y_nxt;
      VGA_COLOR <= w_vga_color_nxt;
      plot      <= w_plot_nxt;
      busy      <= (w_state_nxt != IDLE);
      done      <= (w_state_nxt == DONE);
      if (w_load) begin
        r_x0    <= x0;
        r_y0    <= y0;
        r_w     <= width;
        r_h     <= height;
        r_color <= color;
      end
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_load          = 1'b0;
    w_i_nxt         = r_i;
    w_j_nxt         = r_j;
    w_emit          = 1'b0;
    w_base_x        = r_x0;
    w_base_y        = r_y0;
    w_color         = r_color;
    w_last          = (r_i == r_w - 8'd1) && (r_j == r_h - 7'd1);

    case (r_state)
      IDLE: begin
        if (start) begin
          w_load  = 1'b1;
          w_i_nxt = '0;
          w_j_nxt = '0;
          if (width == 8'd0 || height == 7'd0) begin
            w_state_nxt = DONE;
          end else begin
            // First pixel comes straight from the inputs so it shows one cycle after acceptance
            w_state_nxt = DRAW;
            w_emit      = 1'b1;
            w_base_x    = x0;
            w_base_y    = y0;
            w_color     = color;
          end
        end
      end
      DRAW: begin
        if (w_last) begin
          w_state_nxt = DONE;
        end else begin
          w_emit = 1'b1;
          if (r_i == r_w - 8'd1) begin
            w_i_nxt = '0;
            w_j_nxt = r_j + 7'd1;
          end else begin
            w_i_nxt = r_i + 8'd1;
          end
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    // Widened adds keep off-screen coordinates from wrapping back onto the screen
    w_px_x          = {1'b0, w_base_x} + {1'b0, w_i_nxt};
    w_px_y          = {1'b0, w_base_y} + {1'b0, w_j_nxt};
    w_visible       = (w_px_x < c_x_lim) && (w_px_y < c_y_lim);
    w_plot_nxt      = w_emit && w_visible;
    w_vga_x_nxt     = w_plot_nxt ? w_px_x[7:0] : VGA_X;
    w_vga_y_nxt     = w_plot_nxt ? w_px_y[6:0] : VGA_Y;
    w_vga_color_nxt = w_plot_nxt ? w_color : VGA_COLOR;
  end

endmodule

`default_nettype wire

// File: doc/rect_fill.md
RECT_FILL -- requirements
Module: rect_fill

Interface
REQ-001 Parameter X_MAX, default 160: screen width in pixels; legal columns 0..X_MAX-1.
REQ-002 Parameter Y_MAX, default 120: screen height in pixels; legal rows 0..Y_MAX-1.
REQ-003 CLOCK_50  in  1: the single clock; all state changes on the rising edge.
REQ-004 resetn  in  1: asynchronous, active-low reset.
REQ-005 start  in  1: request to draw; sampled only in IDLE.
REQ-006 x0  in  8: left column of the rectangle.
REQ-007 y0  in  7: top row of the rectangle.
REQ-008 width  in  8: rectangle width in pixels; 0 means empty.
REQ-009 height  in  7: rectangle height in pixels; 0 means empty.
REQ-010 color  in  3: fill colour, 0-7.
REQ-011 VGA_X  out  8: pixel column to the downstream pixel sink.
REQ-012 VGA_Y  out  7: pixel row to the downstream pixel sink.
REQ-013 VGA_COLOR  out  3: pixel colour to the downstream pixel sink.
REQ-014 plot  out  1: one-cycle write strobe; the sink draws VGA_X/VGA_Y/VGA_COLOR in every cycle plot=1.
REQ-015 busy  out  1: high in DRAW and DONE.
REQ-016 done  out  1: one-cycle pulse at the end of each accepted request.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, DRAW and DONE.
REQ-018 In IDLE with start=1, the block SHALL latch x0, y0, width, height and color on that edge and enter DRAW; if width=0 or height=0 it SHALL enter DONE instead.
REQ-019 The block SHALL ignore start while busy=1, and later changes to x0..color SHALL NOT affect a request already in progress.
REQ-020 DRAW SHALL visit one pixel per cycle in raster order, column offset fastest: (x0+i, y0+j) for j=0..height-1 and i=0..width-1.
REQ-021 The first visited pixel SHALL appear on the outputs in the first cycle after the accepting edge.
REQ-022 DRAW SHALL last exactly width*height cycles, then the FSM SHALL enter DONE.
REQ-023 Pixel coordinates SHALL be computed at 9 bits (x) and 8 bits (y) with no wrap-around.
REQ-024 A visited pixel with x >= X_MAX or y >= Y_MAX SHALL be clipped: it still consumes its cycle, and plot=0 for that cycle.
REQ-025 For an unclipped visited pixel, plot=1, VGA_X/VGA_Y carry the low 8/7 bits of the coordinate, and VGA_COLOR carries the latched colour.
REQ-026 DONE SHALL last one cycle with done=1 and plot=0, then return to IDLE; start is not accepted in DONE.
REQ-027 Outside DRAW, plot SHALL be 0, and VGA_X/VGA_Y/VGA_COLOR SHALL hold their last driven values.
REQ-028 All outputs SHALL be registered.

Reset
REQ-029 resetn=0 SHALL immediately force IDLE, VGA_X=0, VGA_Y=0, VGA_COLOR=0, plot=0, busy=0, done=0, and clear all counters and latched operands.
REQ-030 An assertion of reset during DRAW or DONE SHALL abandon the request with no further plot and no done pulse.
REQ-031 After resetn deasserts, the first start SHALL be accepted on the first rising edge on which it is sampled high.

Verification
REQ-032 2x2 fill: x0=5, y0=3, width=2, height=2, color=4, start for one cycle -> plots (5,3),(6,3),(5,4),(6,4) with colour 4 in cycles 1-4 after acceptance; done=1 in cycle 5; busy=0 in cycle 6.
REQ-033 Empty fill: width=0, height=5, start -> no plot; busy=1 and done=1 in cycle 1; IDLE in cycle 2.
REQ-034 Clipped fill: x0=158, y0=119, width=4, height=2 -> 8 DRAW cycles; plot only for (158,119) and (159,119) in cycles 1-2; done in cycle 9.
REQ-035 Busy start: during a 3x3 fill, pulse start with different operands in cycle 4 -> still exactly 9 plots of the original rectangle, one done pulse, and the second request is not executed.
REQ-036 Reset mid-draw: assert resetn=0 in cycle 3 of a 4x4 fill -> all outputs 0 at once, no done pulse; a new 1x1 fill at (0,0) then completes normally.
REQ-037 Full-screen boundary: x0=0, y0=0, width=160, height=120 -> 19200 plots; the last plot is (159,119), followed by done.
